// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: captures a request vector and emits one set-bit index per beat.
// Optional out_last port is enabled by defining PRIO_ENC_LAST_EN.
module prio_encoder_seq #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
`ifdef PRIO_ENC_LAST_EN
  ,
  output logic             out_last
`endif
);

  localparam logic [N-1:0] One = N'(1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             single;
  logic             beat;
  logic             accept;

  function automatic logic [IDX_W-1:0] prio_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    // Later matches overwrite earlier ones, so scan toward the winning end.
    for (int i = 0; i < N; i++) begin
      int j;
      j = MSB_FIRST ? i : (N - 1 - i);
      if (v[j]) idx = IDX_W'(unsigned'(j));
    end
    return idx;
  endfunction

  always_comb begin
    single    = (pend_q != '0) && ((pend_q & (pend_q - One)) == '0);
    busy      = (state_q == StBusy);
    out_valid = busy & en & ~rst;
    in_ready  = en & ~rst & ((state_q == StIdle) | (busy & out_ready & single));
    beat      = out_valid & out_ready;
    accept    = in_valid & in_ready;
    out_idx   = idx_q;

    pend_d = pend_q;
    if (beat) pend_d = pend_q & ~(One << idx_q);
    // Accept only happens when idle or on the final beat, so it overrides the clear.
    if (accept) pend_d = in_vec;

    state_d = (pend_d != '0) ? StBusy : StIdle;
    // Index is registered so it stays stable under back-pressure and holds through idle.
    idx_d   = (pend_d != '0) ? prio_idx(pend_d) : idx_q;
  end

`ifdef PRIO_ENC_LAST_EN
  always_comb begin
    out_last = out_valid & single;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Randomised plus directed bench for prio_encoder_seq; MSB-first and LSB-first instances share
// stimulus and are checked against a queue-of-indices reference model.
module tb_prio_encoder_seq;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  in_vec = '0;
  logic          rdy_m, val_m, busy_m, rdy_l, val_l, busy_l;
  logic [IW-1:0] idx_m, idx_l;
`ifdef PRIO_ENC_LAST_EN
  logic          last_m, last_l;
`endif

  always #5 clk = ~clk;

  prio_encoder_seq #(.N(N), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_m), .in_vec(in_vec),
    .out_valid(val_m), .out_ready(out_ready), .out_idx(idx_m), .busy(busy_m)
`ifdef PRIO_ENC_LAST_EN
    , .out_last(last_m)
`endif
  );

  prio_encoder_seq #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_l), .in_vec(in_vec),
    .out_valid(val_l), .out_ready(out_ready), .out_idx(idx_l), .busy(busy_l)
`ifdef PRIO_ENC_LAST_EN
    , .out_last(last_l)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  // Pending indices in emission order for each priority direction.
  int q_m[$];
  int q_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a vector becomes an ordered list of indices; each beat pops one.
  always @(posedge clk) begin
    if (rst) begin
      q_m.delete();
      q_l.delete();
    end else if (en) begin
      bit rdy, bt;
      rdy = (q_m.size() == 0) || (q_m.size() == 1 && out_ready);
      bt  = (q_m.size() != 0) && out_ready;
      if (bt) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (rdy && in_valid) begin
        for (int i = 0; i < N; i++) begin
          if (in_vec[N-1-i]) q_m.push_back(N - 1 - i);
          if (in_vec[i]) q_l.push_back(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic eb, ev, er;
      eb = (q_m.size() != 0);
      ev = eb & en & ~rst;
      er = en & ~rst & ((q_m.size() == 0) || (q_m.size() == 1 && out_ready));
      chk("busy_m", busy_m, eb);
      chk("busy_l", busy_l, eb);
      chk("valid_m", val_m, ev);
      chk("valid_l", val_l, ev);
      chk("ready_m", rdy_m, er);
      chk("ready_l", rdy_l, er);
      if (ev) begin
        chk("idx_m", idx_m, q_m[0]);
        chk("idx_l", idx_l, q_l[0]);
      end
`ifdef PRIO_ENC_LAST_EN
      chk("last_m", last_m, ev & (q_m.size() == 1));
      chk("last_l", last_l, ev & (q_l.size() == 1));
`endif
    end
  end

  task automatic step(input logic r, input logic e, input logic v, input logic [N-1:0] vec,
                      input logic ordy);
    @(posedge clk);
    #1;
    rst = r; en = e; in_valid = v; in_vec = vec; out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_on = 1'b1;
    chk("rst_valid", val_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_idx", idx_m, 0);
    chk("rst_ready", rdy_m, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("idle_ready", rdy_m, 1);

    // MSB-first 7,5,2 and LSB-first 2,5,7
    step(1'b0, 1'b1, 1'b1, 8'hA4, 1'b1);
    chk("t1_ready", rdy_m, 1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t1_model_len", q_m.size(), 3);
    chk("t1_model_head", q_m[0], 7);
    chk("t1_idx_m0", idx_m, 7);
    chk("t1_idx_l0", idx_l, 2);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t1_idx_m1", idx_m, 5);
    chk("t1_idx_l1", idx_l, 5);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t1_idx_m2", idx_m, 2);
    chk("t1_idx_l2", idx_l, 7);
`ifdef PRIO_ENC_LAST_EN
    chk("t1_last", last_m, 1);
`endif
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t1_busy_fall", busy_m, 0);

    // Back-pressure holds index 7
    step(1'b0, 1'b1, 1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("t2_hold_valid", val_m, 1);
      chk("t2_hold_idx", idx_m, 7);
      chk("t2_hold_ready", rdy_m, 0);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t2_idx7", idx_m, 7);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t2_idx0", idx_m, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t2_idle", busy_m, 0);

    // Zero vector is dropped
    step(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    chk("t3_ready0", rdy_m, 1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t3_busy", busy_m, 0);
    chk("t3_valid", val_m, 0);
    chk("t3_ready1", rdy_m, 1);

    // Back-to-back without a bubble
    step(1'b0, 1'b1, 1'b1, 8'h02, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h10, 1'b1);
    chk("t4_idx1", idx_m, 1);
    chk("t4_ready_last", rdy_m, 1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t4_valid4", val_m, 1);
    chk("t4_idx4", idx_m, 4);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t4_idle", busy_m, 0);

    // Enable freeze
    step(1'b0, 1'b1, 1'b1, 8'h60, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t5_idx6", idx_m, 6);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_off_valid", val_m, 0);
    chk("t5_off_ready", rdy_m, 0);
    chk("t5_off_busy", busy_m, 1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t5_valid5", val_m, 1);
    chk("t5_idx5", idx_m, 5);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t5_idle", busy_m, 0);

    // Reset mid-drain
    step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t6_idx7", idx_m, 7);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t6_rst_valid", val_m, 0);
    chk("t6_rst_ready", rdy_m, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t6_busy", busy_m, 0);
    chk("t6_valid", val_m, 0);
    chk("t6_ready", rdy_m, 1);

    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = N'(1) << $urandom_range(0, N - 1);
        default: v = N'($urandom);
      endcase
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
           v, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
